// File: rtl/bit_merger_piso.sv
// Parallel-in/serial-out bit merger: interleaves an even/odd lane word pair onto one serial line, LSB first.
// Optional trailing even-parity bit per frame when BIT_MERGER_PARITY_EN is defined.
module bit_merger_piso #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] even_in,
    input  logic [WIDTH-1:0] odd_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             phase,
    output logic             frame_done
);

    localparam int CNT_W = $clog2(2*WIDTH+1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(2*WIDTH-1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT
`ifdef BIT_MERGER_PARITY_EN
        ,
        PARITY
`endif
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] sr;
    logic [2*WIDTH-1:0] ilv;
    logic               at_end;
    logic               load;
`ifdef BIT_MERGER_PARITY_EN
    logic               par;
`endif

    // Pre-interleave the pair so the serializer is a plain right shift.
    always_comb begin
        ilv = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ilv[2*i]   = even_in[i];
            ilv[2*i+1] = odd_in[i];
        end
    end

`ifdef BIT_MERGER_PARITY_EN
    assign at_end = (state == PARITY);
`else
    assign at_end = (state == SHIFT) && (cnt == LAST);
`endif

    assign load_ready = !reset && ((state == IDLE) || (at_end && shift_en));
    assign frame_done = at_end && shift_en;
    assign load       = load_valid && load_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            sr        <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            phase     <= 1'b0;
`ifdef BIT_MERGER_PARITY_EN
            par       <= 1'b0;
`endif
        end else if (load) begin
            state     <= SHIFT;
            cnt       <= '0;
            sr        <= ilv >> 1;
            ser_out   <= ilv[0];
            ser_valid <= 1'b1;
            phase     <= 1'b0;
`ifdef BIT_MERGER_PARITY_EN
            par       <= ^ilv;
`endif
        end else begin
            case (state)
                SHIFT: begin
                    if (shift_en) begin
                        if (cnt == LAST) begin
`ifdef BIT_MERGER_PARITY_EN
                            state     <= PARITY;
                            ser_out   <= par;
                            phase     <= 1'b0;
`else
                            state     <= IDLE;
                            cnt       <= '0;
                            ser_out   <= 1'b0;
                            ser_valid <= 1'b0;
                            phase     <= 1'b0;
`endif
                        end else begin
                            cnt     <= cnt + CNT_W'(1);
                            sr      <= sr >> 1;
                            ser_out <= sr[0];
                            phase   <= ~phase;
                        end
                    end
                end
`ifdef BIT_MERGER_PARITY_EN
                PARITY: begin
                    if (shift_en) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        ser_out   <= 1'b0;
                        ser_valid <= 1'b0;
                        phase     <= 1'b0;
                    end
                end
`endif
                IDLE: begin
                    ser_out   <= 1'b0;
                    ser_valid <= 1'b0;
                    phase     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
